// File: rtl/uart_pkg.sv
//------------------------------------------------------------------------------
// uart_pkg -- shared definitions for the UART transmit framer.
//   state_t   : framer FSM states (PARITY exists only when UART_TX_PARITY_EN
//               is defined)
//   MIN_DIV   : smallest usable clocks-per-bit; smaller divisors are clamped
//   BIT_IDX_W : width of the bit_idx output
//------------------------------------------------------------------------------
`timescale 1ns/1ps
package uart_pkg;

  localparam int MIN_DIV   = 2;
  localparam int BIT_IDX_W = 4;

  typedef enum logic [2:0] {
    IDLE,
    START,
    DATA,
`ifdef UART_TX_PARITY_EN
    PARITY,
`endif
    STOP
  } state_t;

endpackage

// File: rtl/uart_tx_framer_if.sv
//------------------------------------------------------------------------------
// uart_tx_framer_if -- payload handshake between a producer and the framer.
//   tx_data    : frame payload (DATA_W bits)
//   tx_valid   : payload offered by the producer
//   tx_ready   : framer can accept (driven by the framer)
//   parity_odd : 1 = odd, 0 = even parity; only with UART_TX_PARITY_EN
// Modports: master (producer side), slave (framer side).
//------------------------------------------------------------------------------
`timescale 1ns/1ps
interface uart_tx_framer_if #(
  parameter int DATA_W = 8
);

  logic [DATA_W-1:0] tx_data;
  logic              tx_valid;
  logic              tx_ready;

`ifdef UART_TX_PARITY_EN
  logic              parity_odd;

  modport master (output tx_data, output tx_valid, output parity_odd, input tx_ready);
  modport slave  (input tx_data, input tx_valid, input parity_odd, output tx_ready);
`else
  modport master (output tx_data, output tx_valid, input tx_ready);
  modport slave  (input tx_data, input tx_valid, output tx_ready);
`endif

endinterface

// File: rtl/uart_baud_tick.sv
//------------------------------------------------------------------------------
// uart_baud_tick -- prescale counter for the UART framer.
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   divisor  : clocks per bit (already clamped to >= 2 by the caller)
//   enable   : count while high; counter is held at 0 while low
//   bit_tick : one-cycle pulse when the count reaches divisor-1
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_baud_tick #(
  parameter int DIV_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [DIV_W-1:0] divisor,
  input  logic             enable,
  output logic             bit_tick
);

  logic [DIV_W-1:0] cnt_reg;

  assign bit_tick = enable && (cnt_reg == (divisor - DIV_W'(1)));

  // Wrapping on the tick keeps the pulse exactly one cycle wide and makes
  // every bit, including the first, last exactly 'divisor' cycles.
  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      cnt_reg <= '0;
    end else if (!enable || bit_tick) begin
      cnt_reg <= '0;
    end else begin
      cnt_reg <= cnt_reg + DIV_W'(1);
    end
  end

endmodule

// File: rtl/uart_tx_framer.sv
//------------------------------------------------------------------------------
// uart_tx_framer -- serialises one payload per frame:
//   start (0), DATA_W data bits LSB first, optional parity, STOP_W stop bits (1).
// Optional feature macro: UART_TX_PARITY_EN (adds parity bit and parity_odd).
//   clk      : clock, rising edge
//   rst      : asynchronous active-low reset
//   baud_div : clocks per bit, latched on transfer (0 and 1 act as 2)
//   bus      : slave side of uart_tx_framer_if (tx_data/tx_valid/tx_ready
//              and parity_odd when enabled)
//   tx_out   : registered serial line, idle high
//   busy     : frame in progress
//   bit_idx  : index of the bit on the line (0 = start, 0 when idle)
//   done     : one-cycle pulse in the first idle cycle after a frame
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module uart_tx_framer
  import uart_pkg::*;
#(
  parameter int DATA_W = 8,
  parameter int STOP_W = 1,
  parameter int DIV_W  = 16
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic [DIV_W-1:0]     baud_div,
  uart_tx_framer_if.slave      bus,
  output logic                 tx_out,
  output logic                 busy,
  output logic [BIT_IDX_W-1:0] bit_idx,
  output logic                 done
);

`ifdef UART_TX_PARITY_EN
  localparam int P = 1;
`else
  localparam int P = 0;
`endif

  localparam logic [BIT_IDX_W-1:0] LAST_DATA_IDX = BIT_IDX_W'(DATA_W);
  localparam logic [BIT_IDX_W-1:0] LAST_STOP_IDX = BIT_IDX_W'(DATA_W + P + STOP_W);
  localparam logic [DIV_W-1:0]     MIN_DIV_V     = DIV_W'(MIN_DIV);

  state_t            state_reg;
  logic [DATA_W-1:0] shift_reg;
  logic [DIV_W-1:0]  div_reg;
  logic              tx_ready_reg;
  logic              bit_tick;
`ifdef UART_TX_PARITY_EN
  logic              parity_reg;
`endif

  assign bus.tx_ready = tx_ready_reg;

  uart_baud_tick #(.DIV_W(DIV_W)) u_baud_tick (
    .clk      (clk),
    .rst      (rst),
    .divisor  (div_reg),
    .enable   (state_reg != IDLE),
    .bit_tick (bit_tick)
  );

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_reg    <= IDLE;
      shift_reg    <= '0;
      div_reg      <= '0;
      tx_ready_reg <= 1'b1;
      tx_out       <= 1'b1;
      busy         <= 1'b0;
      bit_idx      <= '0;
      done         <= 1'b0;
`ifdef UART_TX_PARITY_EN
      parity_reg   <= 1'b0;
`endif
    end else begin
      done <= 1'b0;
      case (state_reg)
        IDLE: begin
          // tx_ready is high throughout IDLE, so tx_valid alone is a transfer.
          if (bus.tx_valid) begin
            state_reg    <= START;
            shift_reg    <= bus.tx_data;
            div_reg      <= (baud_div < MIN_DIV_V) ? MIN_DIV_V : baud_div;
            tx_ready_reg <= 1'b0;
            tx_out       <= 1'b0;
            busy         <= 1'b1;
            bit_idx      <= '0;
`ifdef UART_TX_PARITY_EN
            parity_reg   <= (^bus.tx_data) ^ bus.parity_odd;
`endif
          end
        end
        START: begin
          if (bit_tick) begin
            state_reg <= DATA;
            tx_out    <= shift_reg[0];
            shift_reg <= shift_reg >> 1;
            bit_idx   <= bit_idx + BIT_IDX_W'(1);
          end
        end
        DATA: begin
          if (bit_tick) begin
            bit_idx <= bit_idx + BIT_IDX_W'(1);
            if (bit_idx == LAST_DATA_IDX) begin
`ifdef UART_TX_PARITY_EN
              state_reg <= PARITY;
              tx_out    <= parity_reg;
`else
              state_reg <= STOP;
              tx_out    <= 1'b1;
`endif
            end else begin
              tx_out    <= shift_reg[0];
              shift_reg <= shift_reg >> 1;
            end
          end
        end
`ifdef UART_TX_PARITY_EN
        PARITY: begin
          if (bit_tick) begin
            state_reg <= STOP;
            tx_out    <= 1'b1;
            bit_idx   <= bit_idx + BIT_IDX_W'(1);
          end
        end
`endif
        STOP: begin
          if (bit_tick) begin
            if (bit_idx == LAST_STOP_IDX) begin
              // Frame complete: ready and done rise together in the first
              // idle cycle, so a held tx_valid starts the next frame at once.
              state_reg    <= IDLE;
              tx_ready_reg <= 1'b1;
              busy         <= 1'b0;
              done         <= 1'b1;
              bit_idx      <= '0;
            end else begin
              bit_idx <= bit_idx + BIT_IDX_W'(1);
            end
            tx_out <= 1'b1;
          end
        end
        default: begin
          state_reg <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_uart_tx_framer.sv
//------------------------------------------------------------------------------
// tb_uart_tx_framer -- directed bench for uart_tx_framer.
// DUT a: DATA_W=8, STOP_W=1.  DUT b: DATA_W=5, STOP_W=2.
// Expected frames are built by a small model and queued when a payload is
// offered; they are popped and compared cycle by cycle as the line toggles.
// Honours UART_TX_PARITY_EN for the expected parity bit.
//------------------------------------------------------------------------------
`timescale 1ns/1ps
module tb_uart_tx_framer;

`ifdef UART_TX_PARITY_EN
  localparam int PAR = 1;
`else
  localparam int PAR = 0;
`endif

  logic        clk = 1'b0;
  logic        rst;
  logic [15:0] baud_a, baud_b;
  logic        tx_out_a, busy_a, done_a;
  logic        tx_out_b, busy_b, done_b;
  logic [3:0]  idx_a, idx_b;
  logic        podd_v;
  logic        sel;

  always #5 clk = ~clk;

  uart_tx_framer_if #(.DATA_W(8)) bus_a ();
  uart_tx_framer_if #(.DATA_W(5)) bus_b ();

`ifdef UART_TX_PARITY_EN
  assign bus_a.parity_odd = podd_v;
  assign bus_b.parity_odd = podd_v;
`endif

  uart_tx_framer #(.DATA_W(8), .STOP_W(1), .DIV_W(16)) dut_a (
    .clk(clk), .rst(rst), .baud_div(baud_a), .bus(bus_a),
    .tx_out(tx_out_a), .busy(busy_a), .bit_idx(idx_a), .done(done_a)
  );

  uart_tx_framer #(.DATA_W(5), .STOP_W(2), .DIV_W(16)) dut_b (
    .clk(clk), .rst(rst), .baud_div(baud_b), .bus(bus_b),
    .tx_out(tx_out_b), .busy(busy_b), .bit_idx(idx_b), .done(done_b)
  );

  logic       obs_tx, obs_busy, obs_done, obs_ready;
  logic [3:0] obs_idx;
  assign obs_tx    = sel ? tx_out_b       : tx_out_a;
  assign obs_busy  = sel ? busy_b         : busy_a;
  assign obs_done  = sel ? done_b         : done_a;
  assign obs_ready = sel ? bus_b.tx_ready : bus_a.tx_ready;
  assign obs_idx   = sel ? idx_b          : idx_a;

  typedef struct {
    logic [15:0] bits;
    int          nbits;
    int          div;
  } exp_t;

  exp_t sb_q[$];
  int   errors = 0;
  int   checks = 0;

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  function automatic exp_t build(input logic [8:0] data, input int nd, input int ns,
                                 input logic [15:0] div, input logic podd);
    exp_t e;
    int   n;
    logic p;
    e.bits = '0;
    n      = 0;
    p      = podd;
    e.div  = (div < 16'd2) ? 2 : int'(div);
    e.bits[n] = 1'b0;
    n++;
    for (int i = 0; i < nd; i++) begin
      e.bits[n] = data[i];
      p = p ^ data[i];
      n++;
    end
    if (PAR == 1) begin
      e.bits[n] = p;
      n++;
    end
    for (int i = 0; i < ns; i++) begin
      e.bits[n] = 1'b1;
      n++;
    end
    e.nbits = n;
    return e;
  endfunction

  task automatic set_in(input logic [8:0] data, input logic [15:0] div, input logic valid);
    if (sel == 1'b0) begin
      bus_a.tx_data  = data[7:0];
      baud_a         = div;
      bus_a.tx_valid = valid;
    end else begin
      bus_b.tx_data  = data[4:0];
      baud_b         = div;
      bus_b.tx_valid = valid;
    end
  endtask

  task automatic set_valid(input logic v);
    if (sel == 1'b0) bus_a.tx_valid = v;
    else             bus_b.tx_valid = v;
  endtask

  // Offer a payload at a negedge; returns just after the transfer edge.
  task automatic send(input string tag, input logic [8:0] data, input logic [15:0] div);
    @(negedge clk);
    chk($sformatf("%s_ready", tag), obs_ready, 1);
    set_in(data, div, 1'b1);
    sb_q.push_back(build(data, sel ? 5 : 8, sel ? 2 : 1, div, podd_v));
    @(posedge clk);
  endtask

  // Check one whole frame cycle by cycle, then the done cycle.
  // hold keeps tx_valid high; mid_en changes inputs in cycle 2 of the frame.
  task automatic check_frame(input string tag, input logic hold, input logic mid_en,
                             input logic [8:0] mid_data, input logic [15:0] mid_div);
    exp_t f;
    int   cyc;
    chk($sformatf("%s_sb", tag), (sb_q.size() > 0), 1);
    if (sb_q.size() == 0) return;
    f   = sb_q.pop_front();
    cyc = 0;
    for (int b = 0; b < f.nbits; b++) begin
      for (int c = 0; c < f.div; c++) begin
        @(negedge clk);
        cyc++;
        if (cyc == 1 && !hold) set_valid(1'b0);
        if (cyc == 2 && mid_en) begin
          set_in(mid_data, mid_div, hold);
          if (hold) sb_q.push_back(build(mid_data, sel ? 5 : 8, sel ? 2 : 1, mid_div, podd_v));
        end
        chk($sformatf("%s_tx_b%0d_c%0d", tag, b, c), obs_tx, f.bits[b]);
        chk($sformatf("%s_busy_c%0d", tag, cyc), obs_busy, 1);
        chk($sformatf("%s_idx_c%0d", tag, cyc), obs_idx, b);
        chk($sformatf("%s_ready_c%0d", tag, cyc), obs_ready, 0);
        chk($sformatf("%s_done_c%0d", tag, cyc), obs_done, 0);
      end
    end
    @(negedge clk);
    chk($sformatf("%s_done", tag), obs_done, 1);
    chk($sformatf("%s_end_busy", tag), obs_busy, 0);
    chk($sformatf("%s_end_tx", tag), obs_tx, 1);
    chk($sformatf("%s_end_ready", tag), obs_ready, 1);
    chk($sformatf("%s_end_idx", tag), obs_idx, 0);
  endtask

  initial begin
    logic found;
    sel            = 1'b0;
    podd_v         = 1'b1;
    rst            = 1'b0;
    baud_a         = 16'd4;
    baud_b         = 16'd3;
    bus_a.tx_data  = '0;
    bus_a.tx_valid = 1'b0;
    bus_b.tx_data  = '0;
    bus_b.tx_valid = 1'b0;

    // Reset state
    repeat (3) @(negedge clk);
    chk("rst_tx", obs_tx, 1);
    chk("rst_ready", obs_ready, 1);
    chk("rst_busy", obs_busy, 0);
    chk("rst_done", obs_done, 0);
    chk("rst_idx", obs_idx, 0);
    chk("rst_tx_b", tx_out_b, 1);

    // Release just after an edge; the very next edge carries the transfer.
    @(posedge clk);
    #1 rst = 1'b1;

    // 0xA5, D=4, odd parity then even parity
    send("a5_odd", 9'h0A5, 16'd4);
    check_frame("a5_odd", 1'b0, 1'b0, 9'h0, 16'd0);
    podd_v = 1'b0;
    send("a5_even", 9'h0A5, 16'd4);
    check_frame("a5_even", 1'b0, 1'b0, 9'h0, 16'd0);

    // Back-to-back with tx_valid held; payload changes mid-frame to 0xFF
    send("b2b0", 9'h000, 16'd3);
    check_frame("b2b0", 1'b1, 1'b1, 9'h0FF, 16'd3);
    check_frame("b2b1", 1'b0, 1'b0, 9'h0, 16'd0);

    // Divisor clamp and mid-frame divisor change
    podd_v = 1'b1;
    send("div0", 9'h03C, 16'd0);
    check_frame("div0", 1'b0, 1'b1, 9'h03C, 16'd9);
    send("div9", 9'h0C3, 16'd9);
    check_frame("div9", 1'b0, 1'b0, 9'h0, 16'd0);
    send("div1", 9'h081, 16'd1);
    check_frame("div1", 1'b0, 1'b0, 9'h0, 16'd0);

    // Reset during data bit 3 (data[2]=0, so the line is low there)
    send("abort", 9'h05A, 16'd4);
    found = 1'b0;
    for (int i = 0; i < 200 && !found; i++) begin
      @(negedge clk);
      if (i == 0) set_valid(1'b0);
      if (obs_idx == 4'd3) found = 1'b1;
    end
    chk("abort_reach_idx3", found, 1);
    chk("abort_line_low", obs_tx, 0);
    #1 rst = 1'b0;
    #1;
    chk("abort_tx_async", obs_tx, 1);
    chk("abort_busy", obs_busy, 0);
    chk("abort_idx", obs_idx, 0);
    chk("abort_ready", obs_ready, 1);
    void'(sb_q.pop_front());
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone_rst%0d", i), obs_done, 0);
    end
    @(posedge clk);
    #1 rst = 1'b1;
    for (int i = 0; i < 2; i++) begin
      @(negedge clk);
      chk($sformatf("abort_nodone_post%0d", i), obs_done, 0);
      chk($sformatf("abort_idle_tx%0d", i), obs_tx, 1);
    end
    send("clean", 9'h0A5, 16'd4);
    check_frame("clean", 1'b0, 1'b0, 9'h0, 16'd0);

    // DATA_W=5, STOP_W=2, D=3, payload 0x1F
    sel = 1'b1;
    send("w5", 9'h01F, 16'd3);
    check_frame("w5", 1'b0, 1'b0, 9'h0, 16'd0);

    chk("sb_drained", sb_q.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/uart_tx_framer.md
UART_TX_FRAMER -- requirements
Module: uart_tx_framer

Interface
REQ-001 Parameter DATA_W, default 8, data bits per frame; legal range 5..9.
REQ-002 Parameter STOP_W, default 1, stop bits per frame; legal values 1 or 2.
REQ-003 Parameter DIV_W, default 16, width of the baud divisor.
REQ-004 Port clk, input, 1, single clock; all state on rising edge.
REQ-005 Port rst, input, 1, asynchronous active-low reset.
REQ-006 Port baud_div, input, DIV_W, clocks per bit.
REQ-007 Port tx_data, input, DATA_W, frame payload.
REQ-008 Port tx_valid, input, 1, payload offered.
REQ-009 Port tx_ready, output, 1, framer can accept.
REQ-010 Port parity_odd, input, 1, 1 = odd parity, 0 = even parity; present only with UART_TX_PARITY_EN.
REQ-011 Port tx_out, output, 1, serial line; idle high.
REQ-012 Port busy, output, 1, frame in progress.
REQ-013 Port bit_idx, output, 4, index of the bit currently driven.
REQ-014 Port done, output, 1, one-cycle end-of-frame pulse.

Function
REQ-015 The FSM SHALL have states IDLE, START, DATA, PARITY and STOP; PARITY SHALL exist only with UART_TX_PARITY_EN.
REQ-016 tx_ready SHALL be 1 only in IDLE, and a transfer SHALL occur on any cycle where tx_valid and tx_ready are both 1.
REQ-017 On transfer, the block SHALL latch tx_data, baud_div and parity_odd; input changes mid-frame SHALL have no effect.
REQ-018 A latched baud_div of 0 or 1 SHALL be treated as 2.
REQ-019 tx_out SHALL be registered: the start bit (0) SHALL appear in the cycle after transfer.
REQ-020 Each bit SHALL be held for exactly the latched divisor D cycles, timed by a prescale counter that counts 0..D-1.
REQ-021 Bit order SHALL be: start, then data LSB first, then parity (if enabled), then STOP_W high stop bits.
REQ-022 bit_idx SHALL be 0 for start, increment by 1 per bit, and read 0 in IDLE.
REQ-023 After the final stop-bit cycle, the FSM SHALL enter IDLE; done SHALL pulse in that first IDLE cycle, and tx_ready SHALL be 1 in the same cycle.
REQ-024 tx_valid asserted while busy=1 SHALL be ignored, with no queuing.
REQ-025 busy SHALL be 1 from the cycle after transfer through the last stop-bit cycle.
REQ-026 The frame length SHALL be (1 + DATA_W + P + STOP_W) * D cycles, where P = 1 if parity is enabled and 0 otherwise.

Reset
REQ-027 Reset asserted SHALL force immediately: tx_out=1, tx_ready=1, busy=0, done=0, bit_idx=0, FSM=IDLE, counters=0.
REQ-028 Reset mid-frame SHALL abort the frame, raise tx_out without waiting for clk, and produce no done pulse.
REQ-029 After reset deasserts, the first transfer SHALL be possible on the first clk edge.

Configuration
REQ-030 With UART_TX_PARITY_EN defined, the block SHALL insert one parity bit after the data bits: the XOR of the data bits, inverted when parity_odd=1.
REQ-031 Without UART_TX_PARITY_EN, the parity_odd port and the PARITY state SHALL be absent, and P=0.

Structure
REQ-032 Package uart_pkg SHALL hold the FSM state enumeration, the minimum-divisor constant (2) and the bit_idx width constant (4).
REQ-033 The prescale counter SHALL be a sub-module uart_baud_tick (inputs: divisor and enable; output: one-cycle bit_tick on count D-1).

Verification
REQ-034 With DATA_W=8, STOP_W=1, no parity, baud_div=4, send 0xA5 -> tx_out sequence 0,1,0,1,0,0,1,0,1,1, each bit 4 cycles; done 41 cycles after transfer.
REQ-035 With parity enabled, parity_odd=1, send 0xA5 (four ones) -> parity bit 1; with parity_odd=0 -> parity bit 0; frame is 44 cycles at D=4.
REQ-036 With tx_valid held high and 0x00, 0xFF queued back-to-back -> second start bit begins 1 cycle after done, tx_ready is high only in IDLE cycles, and no data is lost.
REQ-037 With baud_div=0 -> every bit lasts 2 cycles; changing baud_div to 9 mid-frame -> no change until the next transfer.
REQ-038 Assert rst during the DATA bit at bit_idx=3 -> tx_out=1 with no clk edge, no done pulse, and the next transfer after deassertion is a clean frame.
REQ-039 With STOP_W=2, DATA_W=5, D=3, send 0x1F -> 8 bits, 24 cycles, and two high stop bits before done.
